// File: rtl/mem_ctrl_pkg.sv
// Shared op encodings, controller states and byte/half lane helpers for the
// data-memory access controller and its load extender.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } mem_state_e;

  function automatic logic is_load(input mem_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [15:0] half_sel(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

  // Read-modify-write merge: only the addressed lane of the read word changes.
  function automatic logic [31:0] rmw_merge(input logic [31:0] w, input logic [31:0] d,
                                            input logic [1:0] lane, input mem_op_e op);
    logic [31:0] r;
    r = w;
    if (op == OP_SB) begin
      case (lane)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (op == OP_SH) begin
      if (lane[1]) r[31:16] = d[15:0];
      else         r[15:0]  = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic misaligned(input mem_op_e op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load lane select with sign/zero extension of the read word.
// Zero latency; no flow control.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  mem_op_e     op_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  assign byte_w = byte_sel(word_i, addr_lo_i);
  assign half_w = half_sel(word_i, addr_lo_i[1]);

  always_comb begin
    result_o = word_i;
    case (op_i)
      OP_LH:   result_o = {{16{half_w[15]}}, half_w};
      OP_LHU:  result_o = {16'h0000, half_w};
      OP_LB:   result_o = {{24{byte_w[7]}}, byte_w};
      OP_LBU:  result_o = {24'h000000, byte_w};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU load/store to word-wide memory controller (RMW for SH/SB, timeout abort); done 2 (SH/SB 3)
// cycles after accept plus one per mem_ready-low cycle. MEM_MISALIGN_TRAP_EN enables alignment traps.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_align,
  output logic        exc_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  mem_op_e     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  mem_op_e     op_in;
  logic        align_err;
  logic        tmo_hit;
  logic [31:0] ext_word;

  assign op_in   = mem_op_e'(op);
  assign tmo_hit = !mem_ready && (cnt_q == TMO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
  assign align_err = misaligned(op_in, addr[1:0]);
`else
  assign align_err = 1'b0;
`endif

  mem_load_ext u_load_ext (
    .word_i    (mem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .op_i      (op_q),
    .result_o  (ext_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (align_err)           state_d = ST_ERR;
          else if (op_in == OP_SW) state_d = ST_WR;
          else                     state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (mem_ready)    state_d = is_load(op_q) ? ST_DONE : ST_WR;
        else if (tmo_hit) state_d = ST_DONE;
      end
      ST_WR: begin
        if (mem_ready || tmo_hit) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter is cleared on accept and on the RD->WR hop so each phase gets a full budget.
  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        tmo_d = 1'b0;
        if (req) begin
          op_d   = op_in;
          addr_d = addr;
          wdat_d = wdata;
          cnt_d  = '0;
        end
      end
      ST_RD: begin
        if (mem_ready) begin
          cnt_d = '0;
          if (is_load(op_q)) rdata_d = ext_word;
          else               wdat_d  = rmw_merge(mem_rdata, wdat_q, addr_q[1:0], op_q);
        end else if (tmo_hit) begin
          tmo_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WR: begin
        if (!mem_ready) begin
          if (tmo_hit) tmo_d = 1'b1;
          else         cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE) || (state_q == ST_ERR);
    exc_timeout = (state_q == ST_DONE) && tmo_q;
`ifdef MEM_MISALIGN_TRAP_EN
    exc_align   = (state_q == ST_ERR);
`else
    exc_align   = 1'b0;
`endif
    mem_req     = (state_q == ST_RD) || (state_q == ST_WR);
    mem_we      = (state_q == ST_WR);
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdat_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with a small word memory and a spec-level reference model.
// Runs with a short timeout so both sides of the timeout boundary are exercised.
module tb_mem_access_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        exc_align;
  logic        exc_timeout;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic [31:0] ref_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .op          (op),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .exc_align   (exc_align),
    .exc_timeout (exc_timeout),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input int o, input logic [31:0] w, input logic [31:0] a);
    int sh;
    logic [31:0] v;
    if (o == 1 || o == 2) begin
      sh = 16 * int'(a[1]);
      v  = (w >> sh) & 32'hFFFF;
      if (o == 1 && v >= 32'h8000) v = v - 32'h10000;
    end else if (o == 3 || o == 4) begin
      sh = 8 * int'(a[1:0]);
      v  = (w >> sh) & 32'hFF;
      if (o == 3 && v >= 32'h80) v = v - 32'h100;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input int o, input logic [31:0] w, input logic [31:0] d,
                                            input logic [31:0] a);
    int sh;
    logic [31:0] m;
    if (o == 6) begin
      sh = 16 * int'(a[1]);
      m  = 32'hFFFF << sh;
      return (w & ~m) | ((d & 32'hFFFF) << sh);
    end else if (o == 7) begin
      sh = 8 * int'(a[1:0]);
      m  = 32'hFF << sh;
      return (w & ~m) | ((d & 32'hFF) << sh);
    end
    return d;
  endfunction

  function automatic bit ref_misal(input int o, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (o == 0 || o == 5) return a[1:0] != 2'b00;
    if (o == 1 || o == 2 || o == 6) return a[0];
    return 1'b0;
`else
    return (o < 0) && (a == 32'h0);
`endif
  endfunction

  // One transaction: w0 = ready-low cycles in the first memory phase, w1 in the second (SH/SB write).
  task automatic run_txn(input int o, input logic [31:0] a, input logic [31:0] d, input int w0, input int w1);
    int idx, exp_lat, wl, n, nwr;
    bit exp_al, exp_to, exp_wr, got;
    logic [31:0] exp_word;
    idx = int'(a[5:2]);
    exp_al = 0; exp_to = 0; exp_wr = 0; exp_word = 32'h0; got = 0; nwr = 0;
    if (ref_misal(o, a)) begin
      exp_al = 1; exp_lat = 1;
    end else if (o < 5) begin
      if (w0 >= T) begin exp_to = 1; exp_lat = T + 1; end
      else begin exp_lat = 2 + w0; ref_rdata = ref_load(o, ref_mem[idx], a); end
    end else if (o == 5) begin
      if (w0 >= T) begin exp_to = 1; exp_lat = T + 1; end
      else begin exp_lat = 2 + w0; exp_wr = 1; exp_word = d; end
    end else begin
      if (w0 >= T) begin exp_to = 1; exp_lat = T + 1; end
      else if (w1 >= T) begin exp_to = 1; exp_lat = w0 + T + 2; end
      else begin exp_lat = 3 + w0 + w1; exp_wr = 1; exp_word = ref_store(o, ref_mem[idx], d, a); end
    end
    if (exp_wr) ref_mem[idx] = exp_word;

    req = 1'b1; op = 3'(o); addr = a; wdata = d;
    mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    @(posedge clk); #1;
    wl = w0;
    for (n = 0; n < 40; n++) begin
      if (done) begin got = 1; break; end
      chk("busy_in_access", 32'(busy), 32'd1);
      if (mem_req) begin
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        if (wl > 0) begin
          mem_ready = 1'b0; mem_rdata = $urandom; wl--;
        end else begin
          mem_ready = 1'b1; mem_rdata = mem[idx];
          if (mem_we) begin
            nwr++;
            chk("mem_wdata", mem_wdata, exp_word);
            mem[idx] = mem_wdata;
          end
          wl = w1;
        end
      end else begin
        chk("mem_we_without_req", 32'(mem_we), 32'd0);
        mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      end
      req = 1'($urandom_range(0, 1)); op = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
      @(posedge clk); #1;
    end
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("latency", 32'(n + 1), 32'(exp_lat));
      chk("exc_align", 32'(exc_align), 32'(exp_al));
      chk("exc_timeout", 32'(exc_timeout), 32'(exp_to));
      chk("mem_req_at_done", 32'(mem_req), 32'd0);
      chk("rdata", rdata, ref_rdata);
      req = 1'b0; mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_not_busy", 32'(busy), 32'd0);
      chk("exc_cleared", 32'({exc_align, exc_timeout}), 32'd0);
    end else begin
      rst = 1'b1; #2; rst = 1'b0; ref_rdata = 32'h0;
      @(posedge clk); #1;
    end
    chk("write_count", 32'(nwr), 32'(exp_wr));
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 7) < 6) return $urandom_range(0, T - 1);
    return T + $urandom_range(0, 1);
  endfunction

  initial begin
    rst = 1'b1; req = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0; ref_rdata = 32'h0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_exc", 32'({exc_align, exc_timeout}), 32'd0);
    chk("rst_mem_req_we", 32'({mem_req, mem_we}), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    mem[0] = 32'hDEADBEEF; ref_mem[0] = mem[0];
    run_txn(0, 32'h100, 32'h0, 0, 0);
    chk("lw_deadbeef", rdata, 32'hDEADBEEF);

    mem[0] = 32'h80FF7F01; ref_mem[0] = mem[0];
    run_txn(3, 32'h103, 32'h0, 0, 0);
    chk("lb_sign", rdata, 32'hFFFFFF80);
    run_txn(4, 32'h103, 32'h0, 1, 0);
    chk("lbu_zero", rdata, 32'h00000080);

    run_txn(1, 32'h102, 32'h0, 0, 0);
`ifndef MEM_MISALIGN_TRAP_EN
    chk("lh_half1", rdata, 32'hFFFF80FF);
`endif

    mem[0] = 32'h11223344; ref_mem[0] = mem[0];
    run_txn(7, 32'h201, 32'h000000AA, 0, 0);
    chk("sb_merge", mem[0], 32'h1122AA44);

    run_txn(0, 32'h104, 32'h0, T, 0);
    run_txn(0, 32'h104, 32'h0, T - 1, 0);
    run_txn(6, 32'h108, 32'h1234ABCD, 1, T);
    run_txn(5, 32'h10C, 32'hCAFEF00D, T + 1, 0);

    // Reset in the middle of a store: no write lands and the next request is accepted.
    req = 1'b1; op = 3'd5; addr = 32'h110; wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    req = 1'b0; mem_ready = 1'b0;
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rdata", rdata, 32'h0);
    @(posedge clk); #3 rst = 1'b0;
    ref_rdata = 32'h0;
    @(posedge clk); #1;
    chk("rst_mid_no_write", mem[4], ref_mem[4]);
    run_txn(0, 32'h110, 32'h0, 0, 0);

    for (int k = 0; k < 80; k++) begin
      run_txn($urandom_range(0, 7), 32'h100 + 32'($urandom_range(0, 63)), $urandom, pick_wait(), pick_wait());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
